ungrouper: RTL and testbench



---
 rtl/ungrouper_pkg.sv | 33 +++
 rtl/ungrouper_vocab_locator.sv | 58 +++++
 rtl/ungrouper.sv | 195 +++++++++++++++++++
 tb/tb_ungrouper.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ungrouper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ungrouper_pkg
// Description : Shared state encoding and constants for the ungrouper.
// Revision    : 1.0 - initial release
// ============================================================================
package ungrouper_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEEK  = 3'd2,
        COPY  = 3'd3,
        SEP   = 3'd4,
        TERM  = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } ungrouper_state;

    localparam logic [2:0] c_ST_IDLE  = IDLE;
    localparam logic [2:0] c_ST_FETCH = FETCH;
    localparam logic [2:0] c_ST_SEEK  = SEEK;
    localparam logic [2:0] c_ST_COPY  = COPY;
    localparam logic [2:0] c_ST_SEP   = SEP;
    localparam logic [2:0] c_ST_TERM  = TERM;
    localparam logic [2:0] c_ST_DONE  = DONE;
    localparam logic [2:0] c_ST_ERR   = ERR;

    // Delimiter between vocab entries, also the separator/terminator written out
    localparam int SEP_BYTE = 0;

endpackage
`default_nettype wire

// File: rtl/ungrouper_vocab_locator.sv
`default_nettype none
// ============================================================================
// Module      : ungrouper_vocab_locator
// Description : Walks vocab memory to the start of the entry for a token ID.
// Revision    : 1.0 - initial release
// ============================================================================
module ungrouper_vocab_locator #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  seek,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] token,
    input  logic [DATA_WIDTH-1:0] val_vocab,
    output logic [ADDR_WIDTH-1:0] av,
    output logic                  found,
    output logic                  fail
);
    import ungrouper_pkg::*;

    localparam logic [DATA_WIDTH-1:0] c_TOK_ONE  = DATA_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_av;
    logic [DATA_WIDTH-1:0] r_remaining;
    logic                  w_delim;
    logic                  w_av_last;

    assign w_delim   = (val_vocab == DATA_WIDTH'(SEP_BYTE));
    assign w_av_last = &r_av;

    // Stepping off the last address would wrap, so the walk fails there
    assign fail  = seek && w_av_last;
    assign found = seek && !w_av_last && w_delim && (r_remaining == c_TOK_ONE);
    assign av    = r_av;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_av        <= '0;
            r_remaining <= '0;
        end else if (start) begin
            r_av        <= '0;
            r_remaining <= token - c_TOK_ONE;
        end else if (seek && !w_av_last) begin
            r_av <= r_av + c_ADDR_ONE;
            if (w_delim) begin
                r_remaining <= r_remaining - c_TOK_ONE;
            end
        end else if (step) begin
            r_av <= r_av + c_ADDR_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ungrouper.sv
`default_nettype none
// ============================================================================
// Module      : ungrouper
// Description : Expands a zero-terminated token stream into vocab byte strings.
//               Optional macro UNGROUPER_SEP_EN writes a zero after each entry.
// Revision    : 1.0 - initial release
// ============================================================================
module ungrouper #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic [DATA_WIDTH-1:0] val_token,
    input  logic [DATA_WIDTH-1:0] val_vocab,
    output logic [ADDR_WIDTH-1:0] at,
    output logic [ADDR_WIDTH-1:0] av,
    output logic [ADDR_WIDTH-1:0] ao,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  ow,
    output logic                  done,
    output logic                  err
);
    import ungrouper_pkg::*;

    localparam logic [DATA_WIDTH-1:0] c_TOK_ONE  = DATA_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = ADDR_WIDTH'(1);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_at;
    logic [ADDR_WIDTH-1:0] r_ao;
    logic [ADDR_WIDTH-1:0] r_wp;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_ow;
    logic                  r_done;
    logic                  r_err;
    logic                  r_first;

    logic [ADDR_WIDTH-1:0] w_av;
    logic                  w_found;
    logic                  w_fail;
    logic                  w_loc_start;
    logic                  w_tok_zero;
    logic                  w_voc_zero;
    logic                  w_at_last;
    logic                  w_wp_last;
    logic                  w_av_last;
    logic                  w_copy_wr;

    assign w_tok_zero = (val_token == '0);
    assign w_voc_zero = (val_vocab == DATA_WIDTH'(SEP_BYTE));
    assign w_at_last  = &r_at;
    assign w_wp_last  = &r_wp;
    assign w_av_last  = &w_av;

    assign w_loc_start = (r_state == c_ST_FETCH) && !w_tok_zero && !w_at_last;
    // r_wp is the next free output address; slot all-ones is kept for the terminator
    assign w_copy_wr   = (r_state == c_ST_COPY) && !w_voc_zero && !w_av_last && !w_wp_last;

    ungrouper_vocab_locator #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_vocab_locator (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_loc_start),
        .seek      (r_state == c_ST_SEEK),
        .step      (w_copy_wr),
        .token     (val_token),
        .val_vocab (val_vocab),
        .av        (w_av),
        .found     (w_found),
        .fail      (w_fail)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_at    <= '0;
            r_ao    <= '0;
            r_wp    <= '0;
            r_dout  <= '0;
            r_ow    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_first <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_ow <= 1'b0;
                    if (cs) begin
                        r_at    <= '0;
                        r_ao    <= '0;
                        r_wp    <= '0;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_FETCH: begin
                    r_ow <= 1'b0;
                    if (w_tok_zero) begin
                        r_state <= c_ST_TERM;
                    end else if (w_at_last) begin
                        r_state <= c_ST_ERR;
                    end else begin
                        r_first <= 1'b1;
                        r_state <= (val_token == c_TOK_ONE) ? c_ST_COPY : c_ST_SEEK;
                    end
                end
                c_ST_SEEK: begin
                    r_ow <= 1'b0;
                    if (w_fail) begin
                        r_state <= c_ST_ERR;
                    end else if (w_found) begin
                        r_first <= 1'b1;
                        r_state <= c_ST_COPY;
                    end
                end
                c_ST_COPY: begin
                    if (w_copy_wr) begin
                        r_ow    <= 1'b1;
                        r_dout  <= val_vocab;
                        r_ao    <= r_wp;
                        r_wp    <= r_wp + c_ADDR_ONE;
                        r_first <= 1'b0;
                    end else begin
                        r_ow <= 1'b0;
                        if (!w_voc_zero || r_first) begin
                            r_state <= c_ST_ERR;
                        end else begin
`ifdef UNGROUPER_SEP_EN
                            r_state <= c_ST_SEP;
`else
                            r_at    <= r_at + c_ADDR_ONE;
                            r_state <= c_ST_FETCH;
`endif
                        end
                    end
                end
`ifdef UNGROUPER_SEP_EN
                c_ST_SEP: begin
                    if (w_wp_last) begin
                        r_ow    <= 1'b0;
                        r_state <= c_ST_ERR;
                    end else begin
                        r_ow    <= 1'b1;
                        r_dout  <= DATA_WIDTH'(SEP_BYTE);
                        r_ao    <= r_wp;
                        r_wp    <= r_wp + c_ADDR_ONE;
                        r_at    <= r_at + c_ADDR_ONE;
                        r_state <= c_ST_FETCH;
                    end
                end
`endif
                c_ST_TERM: begin
                    r_ow    <= 1'b1;
                    r_dout  <= DATA_WIDTH'(SEP_BYTE);
                    r_ao    <= r_wp;
                    r_state <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    r_ow   <= 1'b0;
                    r_done <= 1'b1;
                    if (!cs) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_ERR: begin
                    r_ow   <= 1'b0;
                    r_err  <= 1'b1;
                    r_done <= 1'b1;
                    if (!cs) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_ow    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign at   = r_at;
    assign av   = w_av;
    assign ao   = r_ao;
    assign dout = r_dout;
    assign ow   = r_ow;
    assign done = r_done;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ungrouper.sv
`default_nettype none
// ============================================================================
// Module      : tb_ungrouper
// Description : Self-checking bench for ungrouper against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ungrouper;

`ifdef UNGROUPER_SEP_EN
    localparam bit c_SEP_EN = 1'b1;
`else
    localparam bit c_SEP_EN = 1'b0;
`endif
    localparam int c_TIMEOUT = 300;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs;
    logic [7:0] val_token;
    logic [7:0] val_vocab;
    logic [3:0] at;
    logic [3:0] av;
    logic [3:0] ao;
    logic [7:0] dout;
    logic       ow;
    logic       done;
    logic       err;

    logic [7:0] tok_mem [0:15];
    logic [7:0] voc_mem [0:15];
    logic [3:0] got_a [$];
    logic [7:0] got_d [$];
    logic [7:0] exp_q [$];
    logic [7:0] c1_q [$];
    logic       exp_err;
    logic       done_at_start;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    assign val_token = tok_mem[at];
    assign val_vocab = voc_mem[av];

    ungrouper dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .val_token (val_token),
        .val_vocab (val_vocab),
        .at        (at),
        .av        (av),
        .ao        (ao),
        .dout      (dout),
        .ow        (ow),
        .done      (done),
        .err       (err)
    );

    always @(negedge clk) begin
        if (ow) begin
            got_a.push_back(ao);
            got_d.push_back(dout);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected writes: resolve each token to its vocab entry by counting delimiters
    task automatic run_model();
        int t;
        int s;
        int cnt;
        int p;
        exp_q.delete();
        exp_err = 1'b0;
        for (int a = 0; a < 16; a++) begin
            t = int'(tok_mem[a]);
            if (t == 0) begin
                exp_q.push_back(8'h00);
                return;
            end
            if (a == 15) begin
                exp_err = 1'b1;
                return;
            end
            s = -1;
            if (t == 1) begin
                s = 0;
            end else begin
                cnt = 0;
                for (int q = 0; q < 15; q++) begin
                    if (voc_mem[q] == 8'h00 && s < 0) begin
                        cnt++;
                        if (cnt == t - 1) s = q + 1;
                    end
                end
            end
            if (s < 0 || voc_mem[s] == 8'h00) begin
                exp_err = 1'b1;
                return;
            end
            p = s;
            while (voc_mem[p] != 8'h00) begin
                if (p == 15 || exp_q.size() == 15) begin
                    exp_err = 1'b1;
                    return;
                end
                exp_q.push_back(voc_mem[p]);
                p++;
            end
            if (c_SEP_EN) begin
                if (exp_q.size() == 15) begin
                    exp_err = 1'b1;
                    return;
                end
                exp_q.push_back(8'h00);
            end
        end
    endtask

    task automatic run_dut(input bit hold, output int cycles);
        got_a.delete();
        got_d.delete();
        @(negedge clk);
        cs = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) cs = 1'b0;
        done_at_start = done;
        cycles = 0;
        while (!done && cycles < c_TIMEOUT) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("timeout", 32'(cycles >= c_TIMEOUT), 0);
    endtask

    task automatic compare_run(input string tag);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_nwr"}, got_d.size(), exp_q.size());
        for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_a%0d", tag, i), 32'(got_a[i]), i);
            check($sformatf("%s_d%0d", tag, i), 32'(got_d[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic load_case1(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2);
        logic [7:0] v [0:7];
        v = '{8'h61, 8'h62, 8'h00, 8'h63, 8'h00, 8'h64, 8'h65, 8'h00};
        for (int i = 0; i < 16; i++) begin
            voc_mem[i] = (i < 8) ? v[i] : 8'h00;
            tok_mem[i] = 8'h00;
        end
        tok_mem[0] = t0;
        tok_mem[1] = t1;
        tok_mem[2] = t2;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_at"}, 32'(at), 0);
        check({tag, "_av"}, 32'(av), 0);
        check({tag, "_ao"}, 32'(ao), 0);
        check({tag, "_dout"}, 32'(dout), 0);
        check({tag, "_ow"}, 32'(ow), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        int cyc;
        int w;
        bit ok;
        rst_n = 1'b0;
        cs    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tok_mem[i] = 8'h00;
            voc_mem[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: two tokens, independent expectation as well as the model
        load_case1(8'h02, 8'h01, 8'h00);
        run_model();
        if (c_SEP_EN) c1_q = '{8'h63, 8'h00, 8'h61, 8'h62, 8'h00, 8'h00};
        else          c1_q = '{8'h63, 8'h61, 8'h62, 8'h00};
        run_dut(1'b0, cyc);
        compare_run("case1");
        check("case1_nconst", got_d.size(), c1_q.size());
        for (int i = 0; i < got_d.size() && i < c1_q.size(); i++) begin
            check($sformatf("case1_const%0d", i), 32'(got_d[i]), 32'(c1_q[i]));
        end

        // Empty stream: single terminator and fixed latency
        load_case1(8'h00, 8'h00, 8'h00);
        run_model();
        run_dut(1'b0, cyc);
        compare_run("empty");
        check("empty_latency", cyc, 3);

        // Token beyond the last entry with no further delimiters
        load_case1(8'h05, 8'h00, 8'h00);
        for (int i = 8; i < 16; i++) voc_mem[i] = 8'h7a;
        run_model();
        run_dut(1'b0, cyc);
        compare_run("badtok");
        check("badtok_err", 32'(err), 1);
        check("badtok_nwr", got_d.size(), 0);

        // Reset in the middle of copying token 3
        load_case1(8'h03, 8'h00, 8'h00);
        got_d.delete();
        @(negedge clk);
        cs = 1'b1;
        @(posedge clk);
        #1;
        cs = 1'b0;
        w = 0;
        while (!ow && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("midcopy_ow_seen", 32'(ow), 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_model();
        run_dut(1'b0, cyc);
        compare_run("after_rst");

        // cs held through DONE must not restart; re-raising runs again
        load_case1(8'h02, 8'h01, 8'h00);
        run_model();
        run_dut(1'b1, cyc);
        compare_run("hold");
        ok = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (!done || ow) ok = 1'b0;
        end
        check("hold_stays_done", 32'(ok), 1);
        check("hold_no_extra_wr", got_d.size(), exp_q.size());
        cs = 1'b0;
        @(posedge clk);
        #1;
        check("idle_done_sticky", 32'(done), 1);
        run_dut(1'b0, cyc);
        check("restart_done_low", 32'(done_at_start), 0);
        compare_run("rerun");

        // Randomized streams
        for (int n = 0; n < 40; n++) begin
            int ntok;
            for (int i = 0; i < 16; i++) begin
                voc_mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                tok_mem[i] = 8'($urandom_range(1, 255));
            end
            if ($urandom_range(0, 7) != 0) begin
                ntok = $urandom_range(0, 4);
                for (int i = 0; i < 16; i++) begin
                    if (i < ntok) tok_mem[i] = 8'($urandom_range(1, 6));
                    else if (i == ntok) tok_mem[i] = 8'h00;
                end
            end else begin
                for (int i = 0; i < 16; i++) tok_mem[i] = 8'($urandom_range(1, 2));
            end
            run_model();
            run_dut(1'b0, cyc);
            compare_run($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
